// File: rtl/sevenseg_scan_ctrl.sv
// Scan scheduler for a multiplexed seven-segment display: digit register file,
// blanked time-slicing of the shared segment bus, and per-digit blinking.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYC    = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  output logic                  wr_err,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic [NUM_DIGITS-1:0] Enable,
  output logic [3:0]            digit_code,
  output logic                  frame_done
);

  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned DEPTH   = 1 << IDX_W;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [SLOT_W-1:0]       slot_cnt, slot_nxt;
  logic [IDX_W-1:0]        cur_idx, idx_nxt;
  logic [FRAME_W-1:0]      frame_cnt, frame_nxt;
  logic                    blink_phase, phase_nxt;
  logic [NUM_DIGITS-1:0]   en_nxt;
  logic [3:0]              code_nxt;
  logic                    fd_nxt;
  logic [3:0]              stored [DEPTH];

  logic wr_fire;
  logic wr_in_range;

  // Only the digit currently lit is protected from tearing.
  assign wr_ready    = !(state == SHOW && wr_idx == cur_idx);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = 32'(wr_idx) < NUM_DIGITS;

  // Digit register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stored[i] <= 4'h0;
    end else if (wr_fire && wr_in_range) begin
      stored[wr_idx] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BLANK;
      slot_cnt    <= '0;
      cur_idx     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      Enable      <= '0;
      digit_code  <= 4'h0;
      frame_done  <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot_cnt    <= slot_nxt;
      cur_idx     <= idx_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
      Enable      <= en_nxt;
      digit_code  <= code_nxt;
      frame_done  <= fd_nxt;
      wr_err      <= wr_fire && !wr_in_range;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt + SLOT_W'(1);
    idx_nxt   = cur_idx;
    frame_nxt = frame_cnt;
    phase_nxt = blink_phase;
    en_nxt    = Enable;
    code_nxt  = digit_code;
    fd_nxt    = 1'b0;
    case (state)
      BLANK: begin
        // Capture on the first blank cycle; forward a same-edge write to this digit.
        if (slot_cnt == '0) begin
          code_nxt = (wr_fire && wr_idx == cur_idx) ? wr_data : stored[cur_idx];
        end
        if (slot_cnt == SLOT_W'(BLANK_CYC - 1)) begin
          state_nxt = SHOW;
          en_nxt    = (blink_mask[cur_idx] && blink_phase) ? '0
                                                           : (NUM_DIGITS'(1) << cur_idx);
        end
      end
      SHOW: begin
        if (slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
          state_nxt = BLANK;
          slot_nxt  = '0;
          en_nxt    = '0;
          if (cur_idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
            fd_nxt  = 1'b1;
            if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
              frame_nxt = '0;
              phase_nxt = ~blink_phase;
            end else begin
              frame_nxt = frame_cnt + FRAME_W'(1);
            end
          end else begin
            idx_nxt = cur_idx + IDX_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Scan scheduler for the multiplexed seven-segment display. It owns a small digit register file that other logic writes through a valid/ready port. It time-slices the shared segment bus among NUM_DIGITS digits, inserting a blanking dead-time between digits to prevent ghosting, and applies per-digit blinking. Its outputs feed the existing seven-segment pattern decoder (digit_code) and the digit enables.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (2..8)
SCAN_DIV, 100000, clk cycles per digit slot (blank + show)
BLANK_CYC, 1000, clk cycles of blanking at the start of each slot; must satisfy 1 <= BLANK_CYC < SCAN_DIV
BLINK_FRAMES, 64, full frames per blink phase toggle (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write can be accepted this cycle
wr_idx  in  IDX_W  target digit; IDX_W = max(1, clog2(NUM_DIGITS)); digit 0 = rightmost
wr_data  in  4  nibble to store
wr_err  out  1  one-cycle pulse: an accepted write had wr_idx >= NUM_DIGITS
blink_mask  in  NUM_DIGITS  digit i blinks when bit i = 1
Enable  out  NUM_DIGITS  one-hot digit enable, active-high; Enable[i] drives digit i (2-digit: 2'b01 = right, 2'b10 = left)
digit_code  out  4  nibble for the currently selected digit, to the pattern decoder
frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (async assert, sync to clk on release):
  - Enable = 0, digit_code = 0, wr_err = 0, frame_done = 0, wr_ready = 1.
  - All stored digits = 0; cur_idx = 0; blink phase = 0; frame counter = 0.
  - State = BLANK; slot counter = 0.
- Reset mid-operation: all of the above apply immediately. No pending write survives reset.
- FSM has two states, BLANK and SHOW, with a slot counter counting 0..SCAN_DIV-1.
  - BLANK: Enable = 0. digit_code = stored[cur_idx], registered on the first BLANK cycle and held for the whole slot. After BLANK_CYC cycles, go to SHOW.
  - SHOW: Enable = one-hot(cur_idx), forced to 0 when blink_mask[cur_idx] = 1 and blink phase = 1. Lasts SCAN_DIV - BLANK_CYC cycles.
  - End of SHOW: cur_idx = (cur_idx + 1) mod NUM_DIGITS, then go to BLANK. No gap cycle between slots.
- Enable is registered and changes only at BLANK/SHOW boundaries. digit_code never changes while Enable != 0.
- frame_done: high for the single cycle after the last SHOW cycle of digit NUM_DIGITS-1, which is the first BLANK cycle of digit 0.
- Blink:
  - The frame counter increments on each frame_done.
  - When the counter reaches BLINK_FRAMES it wraps to 0 and blink phase toggles.
  - The new phase takes effect at the next SHOW entry.
- Write port:
  - A write is accepted when wr_valid && wr_ready.
  - stored[wr_idx] updates on that clock edge and becomes visible at the next BLANK entry for that digit.
  - wr_ready = 0 only when state = SHOW and wr_idx == cur_idx, so the digit on display is not torn. wr_ready is combinational from wr_idx and state.
  - Writes to other digits are always accepted.
  - Back-to-back writes are allowed, one per cycle.
  - wr_idx >= NUM_DIGITS: accepted (wr_ready = 1), data dropped, wr_err = 1 on the next cycle.
- Write and BLANK entry on the same edge for the same digit: that write was accepted during the last SHOW cycle of a different digit, so it is stored and is visible on that BLANK entry.
- Counters are modular and do not saturate. Slot counter width = clog2(SCAN_DIV). Frame counter width = clog2(BLINK_FRAMES + 1).

Test Plan:
Use NUM_DIGITS=2, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2 for all scenarios.
1. Reset release, idle inputs -> Enable = 00 for 2 cycles, then 01 for 6 cycles, then 00 for 2, then 10 for 6, repeating. frame_done pulses every 16 cycles, first at cycle 16.
2. Write idx1 = 4'hA and idx0 = 4'h3 during the first BLANK -> digit_code = 3 whenever Enable = 01 and 4'hA whenever Enable = 10. digit_code is stable throughout each slot.
3. Drive wr_valid, idx0, data 5 while Enable = 01 -> wr_ready = 0 until the SHOW ends. The write is accepted on the first BLANK cycle of digit 1, and digit_code = 5 on the next digit-0 slot.
4. blink_mask = 2'b10 -> Enable = 10 during frames 1-2, suppressed (00) during frames 3-4, then restored. Enable = 01 is never suppressed.
5. Write with wr_idx = 1 with NUM_DIGITS=2 is valid. Rerun with NUM_DIGITS=3 and wr_idx = 3 -> write accepted, wr_err pulses one cycle, stored digits unchanged.
6. Assert reset mid-SHOW of digit 1 -> Enable = 0 and digit_code = 0 immediately. After release the sequence restarts at BLANK of digit 0 with all digits cleared.
